// File: rtl/ex_mul_seq.sv
// ex_mul_seq - iterative radix-2 shift-add multiplier for the EX stage.
//
// Serves MULT/MULTU/MADD/MADDU/MSUB/MSUBU. One partial product is added per
// cycle over WIDTH cycles. An optional extra cycle then folds the product into
// the latched {HI,LO} value. All operands are captured when the operation
// starts, so EX may change its operand buses freely afterwards.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start_i        request; EX holds it high until ready_o, then drops it
//   annul_i        pipeline flush; aborts any operation (wins over start_i)
//   signed_i       1 = operands are two's-complement
//   acc_op_i       00 plain, 01 hilo + product, 10 hilo - product, 11 plain
//   opdata1_i      multiplicand
//   opdata2_i      multiplier
//   hilo_i         {HI,LO} accumulator input
//   result_o       final 2*WIDTH value, non-zero only while ready_o is high
//   ready_o        result valid; stays high while start_i is held
//   busy_o         high while multiplying or accumulating
//   state_o        debug view of the FSM state (IDLE/BUSY/ACC/DONE)
//
// Handshake: start_i is a level request. The operation is accepted on the
// first edge with start_i=1 and annul_i=0 in IDLE. ready_o rises once the
// result is final and stays high, with result_o stable, until the edge after
// start_i drops. At least one low cycle of start_i separates two operations.
//
// CNT_W must satisfy 2**CNT_W == WIDTH so the counter indexes every
// multiplier bit exactly once.

module ex_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_i,
  input  logic [1:0]           acc_op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [2*WIDTH-1:0]   hilo_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic [1:0]           state_o
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ACC_ADD = 2'b01;
  localparam logic [1:0] ACC_SUB = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  // State and datapath registers
  state_t            state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [WIDTH-1:0]  mcand_q,  mcand_d;   // |opdata1| (or raw if unsigned)
  logic [WIDTH-1:0]  mplier_q, mplier_d;  // |opdata2| (or raw if unsigned)
  logic              neg_q,    neg_d;     // final product must be negated
  logic [1:0]        acc_op_q, acc_op_d;
  logic [PW-1:0]     hilo_q,   hilo_d;
  logic [PW-1:0]     prod_q,   prod_d;

  // Registered outputs
  logic [PW-1:0]     result_q, result_d;
  logic              ready_q,  ready_d;
  logic              busy_q,   busy_d;

  // Step helpers
  logic [PW-1:0]     partial;
  logic [PW-1:0]     sum;
  logic              acc_needed;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_op_d = acc_op_q;
    hilo_d   = hilo_q;
    prod_d   = prod_q;
    partial  = '0;
    sum      = '0;

    acc_needed = (acc_op_q == ACC_ADD) || (acc_op_q == ACC_SUB);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          // Magnitudes are taken as WIDTH-bit unsigned values, so the most
          // negative operand maps to 2**(WIDTH-1) and multiplies correctly.
          mcand_d  = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
          mplier_d = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
          neg_d    = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          acc_op_d = acc_op_i;
          hilo_d   = hilo_i;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end

      BUSY: begin
        if (mplier_q[cnt_q]) begin
          partial = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
        end
        sum   = prod_q + partial;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Sign correction rides along with the last add.
          prod_d  = neg_q ? -sum : sum;
          state_d = acc_needed ? ACC : DONE;
        end else begin
          prod_d = sum;
        end
      end

      ACC: begin
        // Wraps modulo 2**PW; no overflow indication.
        prod_d  = (acc_op_q == ACC_SUB) ? (hilo_q - prod_q) : (hilo_q + prod_q);
        state_d = DONE;
      end

      DONE: begin
        if (!start_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush beats everything except reset, including a start in IDLE.
    if (annul_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    // Outputs follow the next state so they line up with the state change.
    busy_d   = (state_d == BUSY) || (state_d == ACC);
    ready_d  = (state_d == DONE);
    result_d = ready_d ? prod_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_op_q <= 2'b00;
      hilo_q   <= '0;
      prod_q   <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_op_q <= acc_op_d;
      hilo_q   <= hilo_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_ex_mul_seq.sv
// Directed plus randomized bench for ex_mul_seq.
module tb_ex_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [1:0]  acc_op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] hilo_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  // Clock / reset
  always #5 clk = ~clk;

  ex_mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .acc_op_i  (acc_op_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .hilo_i    (hilo_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .state_o   (state_o)
  );

  // Reference: full-width arithmetic, then accumulate, all mod 2**64.
  function automatic logic [63:0] ref_model(input bit s, input logic [1:0] acc,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [63:0] h);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (s) p = 64'(sa * sb);
    else   p = {32'd0, a} * {32'd0, b};
    case (acc)
      2'b01:   return h + p;
      2'b10:   return h - p;
      default: return p;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one operation and check latency, busy span, result, hold and release.
  task automatic run_op(input string tag, input bit s, input logic [1:0] acc,
                        input logic [31:0] a, input logic [31:0] b, input logic [63:0] h,
                        input logic [63:0] exp, input int hold, input int change_at);
    int lat;
    int ready_edge;
    int busy_cnt;
    lat = (acc == 2'b01 || acc == 2'b10) ? 34 : 33;
    ready_edge = 0;
    busy_cnt = 0;
    @(negedge clk);
    signed_i = s; acc_op_i = acc; opdata1_i = a; opdata2_i = b; hilo_i = h;
    start_i = 1'b1;
    for (int e = 1; e <= 40 && ready_edge == 0; e++) begin
      @(posedge clk); #1;
      if (busy_o) busy_cnt++;
      if (ready_o) ready_edge = e;
      if (e == change_at) begin
        opdata1_i = $urandom; opdata2_i = $urandom;
        hilo_i = {$urandom, $urandom}; signed_i = ~signed_i;
        acc_op_i = 2'($urandom);
      end
    end
    check({tag, " latency"}, 64'(ready_edge), 64'(lat));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
    check({tag, " result"}, result_o, exp);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, " hold ready"}, 64'(ready_o), 64'd1);
      check({tag, " hold result"}, result_o, exp);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " release ready"}, 64'(ready_o), 64'd0);
    check({tag, " release result"}, result_o, 64'd0);
    check({tag, " release busy"}, 64'(busy_o), 64'd0);
  endtask

  // Start an operation, abort after 'at' edges via annul or reset.
  task automatic abort_op(input string tag, input bit use_rst, input int at);
    @(negedge clk);
    signed_i = 1'b0; acc_op_i = 2'b01; opdata1_i = 32'd123; opdata2_i = 32'd456;
    hilo_i = 64'd5; start_i = 1'b1;
    repeat (at) @(posedge clk);
    #1;
    check({tag, " busy before abort"}, 64'(busy_o), 64'd1);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " busy after abort"}, 64'(busy_o), 64'd0);
    check({tag, " ready after abort"}, 64'(ready_o), 64'd0);
    check({tag, " result after abort"}, result_o, 64'd0);
    check({tag, " state after abort"}, 64'(state_o), 64'd0);
    @(negedge clk);
    rst = 1'b0; annul_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    acc_op_i = 2'b00; opdata1_i = '0; opdata2_i = '0; hilo_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result_o, 64'd0);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset state", 64'(state_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with hand-computed results
    run_op("multu_max", 1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0,
           64'hFFFFFFFE_00000001, 0, 0);
    run_op("mult_neg3x5", 1'b1, 2'b00, 32'hFFFFFFFD, 32'd5, 64'd0,
           64'hFFFFFFFF_FFFFFFF1, 0, 0);
    run_op("mult_minmin", 1'b1, 2'b00, 32'h80000000, 32'h80000000, 64'd0,
           64'h40000000_00000000, 0, 0);
    run_op("madd_2x3", 1'b1, 2'b01, 32'd2, 32'd3, 64'h10, 64'h16, 0, 0);
    run_op("msubu_1x1", 1'b0, 2'b10, 32'd1, 32'd1, 64'd0, 64'hFFFFFFFF_FFFFFFFF, 0, 0);
    run_op("acc11_plain", 1'b0, 2'b11, 32'd6, 32'd7, 64'hABCD, 64'd42, 0, 0);
    run_op("input_change", 1'b0, 2'b00, 32'd7, 32'd9, 64'd0, 64'h3F, 0, 5);
    run_op("hold5", 1'b1, 2'b00, 32'd100, 32'hFFFFFFFE, 64'd0,
           64'hFFFFFFFF_FFFFFF38, 5, 0);

    // Aborts and recovery
    abort_op("annul", 1'b0, 10);
    run_op("after_annul", 1'b0, 2'b00, 32'd4, 32'd4, 64'd0, 64'h10, 0, 0);
    abort_op("rst", 1'b1, 20);
    run_op("after_rst", 1'b0, 2'b00, 32'd4, 32'd4, 64'd0, 64'h10, 0, 0);

    // start and annul together in IDLE: nothing begins
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd3; opdata2_i = 32'd3;
    repeat (3) begin
      @(posedge clk); #1;
      check("start_annul busy", 64'(busy_o), 64'd0);
      check("start_annul state", 64'(state_o), 64'd0);
    end
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;

    // Randomized operations against the reference model
    for (int i = 0; i < 20; i++) begin
      bit          s;
      logic [1:0]  acc;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] h;
      s = 1'($urandom_range(0, 1));
      acc = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) a = 32'h80000000;
      if (i % 7 == 0) b = 32'hFFFFFFFF;
      h = {$urandom, $urandom};
      run_op("random", s, acc, a, b, h, ref_model(s, acc, a, b, h),
             $urandom_range(0, 3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
